// File: rtl/visumon_page_sched_pkg.sv
// Shared types and constants for the visuMon page scheduler.
package visumon_page_sched_pkg;
  localparam int DWELL_W = 8;
  localparam int DBG_W   = 32;

  typedef logic [DBG_W-1:0] debug_info_t;
  typedef enum logic {IDLE, SHOW} sched_state_t;
endpackage

// File: rtl/visumon_page_sched_rr_pick.sv
// Combinational round-robin search: first set bit of req at or after start, wrapping.
module rr_pick
  import visumon_page_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          valid,
  output logic [IW-1:0] idx
);
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!valid && req[(int'(start) + i) % N]) begin
        valid = 1'b1;
        idx   = IW'((int'(start) + i) % N);
      end
    end
  end
endmodule

// File: rtl/visumon_page_sched.sv
// Frame-synchronous round-robin sharing of the visuMon debug monitor between probe sources.
// Optional manual page advance via i_step when VISUMON_MANUAL_STEP_EN is defined.
module visumon_page_sched
  import visumon_page_sched_pkg::*;
#(
  parameter int N_SRC        = 4,
  parameter int DWELL_FRAMES = 60
) (
  input  logic                          i_clk25Mhz,
  input  logic                          i_reset,
  input  logic                          i_vsync,
  input  logic [N_SRC-1:0]              i_req,
  input  logic [N_SRC-1:0][DBG_W-1:0]   i_debugInfo,
  input  logic                          i_freeze,
`ifdef VISUMON_MANUAL_STEP_EN
  input  logic                          i_step,
`endif
  output logic                          o_cs,
  output logic [N_SRC-1:0]              o_grant,
  output logic [$clog2(N_SRC)-1:0]      o_page,
  output logic [DBG_W-1:0]              o_debugInfo
);
  localparam int PW = $clog2(N_SRC);
  localparam logic [PW-1:0]      LAST    = PW'(N_SRC - 1);
  localparam logic [DWELL_W-1:0] DW_LAST = DWELL_W'(DWELL_FRAMES - 1);

  sched_state_t       state, state_n;
  logic [PW-1:0]      page, page_n, rr_ptr, rr_n, page_inc;
  logic [DWELL_W-1:0] dwell, dwell_n;
  logic               vs_q, armed, tick, load, step_pend;
  logic [N_SRC-1:0]   other_req;
  logic               idle_vld, rot_vld;
  logic [PW-1:0]      idle_idx, rot_idx;

  // armed blocks a tick until vsync has been seen high since reset, so a
  // vsync stuck low across reset release never produces a frame start.
  assign tick = armed & vs_q & ~i_vsync;

  assign page_inc  = (page == LAST) ? '0 : page + 1'b1;
  assign other_req = i_req & ~o_grant;

  rr_pick #(.N(N_SRC), .IW(PW)) u_pick_idle (
    .req(i_req), .start(rr_ptr), .valid(idle_vld), .idx(idle_idx)
  );

  rr_pick #(.N(N_SRC), .IW(PW)) u_pick_rot (
    .req(other_req), .start(page_inc), .valid(rot_vld), .idx(rot_idx)
  );

`ifdef VISUMON_MANUAL_STEP_EN
  logic step_q, step_clr;
  assign step_clr  = tick & ~((state == SHOW) & i_freeze);
  assign step_pend = step_q | i_step;

  always_ff @(posedge i_clk25Mhz or negedge i_reset) begin
    if (!i_reset)      step_q <= 1'b0;
    else if (step_clr) step_q <= 1'b0;
    else if (i_step)   step_q <= 1'b1;
  end
`else
  assign step_pend = 1'b0;
`endif

  always_comb begin
    state_n = state;
    page_n  = page;
    dwell_n = dwell;
    rr_n    = rr_ptr;
    load    = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (idle_vld) begin
            state_n = SHOW;
            page_n  = idle_idx;
            dwell_n = '0;
            load    = 1'b1;
          end
        end
        SHOW: begin
          if (i_freeze) begin
            // hold everything, including dwell
          end else if (!i_req[page]) begin
            if (rot_vld) begin
              page_n  = rot_idx;
              dwell_n = '0;
              load    = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end else if (dwell == DW_LAST || step_pend) begin
            dwell_n = '0;
            load    = 1'b1;
            if (rot_vld) begin
              page_n = rot_idx;
              rr_n   = (rot_idx == LAST) ? '0 : rot_idx + 1'b1;
            end
          end else begin
            dwell_n = dwell + 1'b1;
            load    = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk25Mhz or negedge i_reset) begin
    if (!i_reset) begin
      state       <= IDLE;
      page        <= '0;
      dwell       <= '0;
      rr_ptr      <= '0;
      vs_q        <= 1'b1;
      armed       <= 1'b0;
      o_debugInfo <= '0;
    end else begin
      state <= state_n;
      page  <= page_n;
      dwell <= dwell_n;
      rr_ptr <= rr_n;
      vs_q  <= i_vsync;
      armed <= armed | i_vsync;
      if (load) o_debugInfo <= i_debugInfo[page_n];
    end
  end

  always_comb begin
    o_grant = '0;
    if (state == SHOW) o_grant[page] = 1'b1;
  end

  assign o_cs   = (state == SHOW);
  assign o_page = page;
endmodule

// File: tb/tb_visumon_page_sched.sv
// Directed self-checking bench for visumon_page_sched (N_SRC=4, DWELL_FRAMES=3).
module tb_visumon_page_sched;
  import visumon_page_sched_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      vsync;
  logic [3:0]                req;
  logic [3:0][DBG_W-1:0]     dbg;
  logic                      freeze;
  logic                      cs;
  logic [3:0]                grant;
  logic [1:0]                page;
  logic [DBG_W-1:0]          dbg_out;
`ifdef VISUMON_MANUAL_STEP_EN
  logic                      step;
`endif

  int nerr = 0;
  int nchk = 0;

  localparam logic [31:0] S0 = 32'h1111_1111;
  localparam logic [31:0] S1 = 32'h2222_2222;
  localparam logic [31:0] S2 = 32'h3333_3333;
  localparam logic [31:0] S3 = 32'h4444_4444;
  localparam logic [31:0] S1B = 32'hBEEF_0001;

  always #20 clk = ~clk;

  visumon_page_sched #(.N_SRC(4), .DWELL_FRAMES(3)) dut (
    .i_clk25Mhz (clk),
    .i_reset    (rst_n),
    .i_vsync    (vsync),
    .i_req      (req),
    .i_debugInfo(dbg),
    .i_freeze   (freeze),
`ifdef VISUMON_MANUAL_STEP_EN
    .i_step     (step),
`endif
    .o_cs       (cs),
    .o_grant    (grant),
    .o_page     (page),
    .o_debugInfo(dbg_out)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One frame: vsync low 3 cycles then high 3; returns on a negedge.
  task automatic frame();
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [3:0]  exp_g [6];
    logic [31:0] exp_d [6];
    rst_n = 1'b0; vsync = 1'b1; req = 4'b0000; freeze = 1'b0;
    dbg[0] = S0; dbg[1] = S1; dbg[2] = S2; dbg[3] = S3;
`ifdef VISUMON_MANUAL_STEP_EN
    step = 1'b0;
`endif
    req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vsync = ~vsync;
      chk("rst_cs", 64'(cs), 64'd0);
      chk("rst_grant", 64'(grant), 64'd0);
    end
    chk("rst_page", 64'(page), 64'd0);
    chk("rst_dbg", 64'(dbg_out), 64'd0);
    req = 4'b0000; vsync = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // first grant, visible one cycle after the fall
    req = 4'b0010;
    vsync = 1'b0;
    @(negedge clk);
    chk("g1_cs", 64'(cs), 64'd1);
    chk("g1_grant", 64'(grant), 64'h2);
    chk("g1_page", 64'(page), 64'd1);
    chk("g1_dbg", 64'(dbg_out), 64'(S1));
    repeat (2) @(negedge clk);
    vsync = 1'b1;
    repeat (3) @(negedge clk);

    // rotation 1 -> 3 -> 1 with dwell of 3 frames
    req = 4'b1010;
    exp_g[0] = 4'b0010; exp_d[0] = S1;
    exp_g[1] = 4'b0010; exp_d[1] = S1;
    exp_g[2] = 4'b1000; exp_d[2] = S3;
    exp_g[3] = 4'b1000; exp_d[3] = S3;
    exp_g[4] = 4'b1000; exp_d[4] = S3;
    exp_g[5] = 4'b0010; exp_d[5] = S1;
    for (int f = 0; f < 6; f++) begin
      frame();
      chk($sformatf("rot_grant%0d", f), 64'(grant), 64'(exp_g[f]));
      chk($sformatf("rot_dbg%0d", f), 64'(dbg_out), 64'(exp_d[f]));
    end

    // mid-frame data change stays hidden; freeze holds page and snapshot
    dbg[1] = S1B;
    repeat (4) @(negedge clk);
    chk("mid_dbg", 64'(dbg_out), 64'(S1));
    freeze = 1'b1;
    for (int f = 0; f < 5; f++) begin
      frame();
      chk($sformatf("frz_grant%0d", f), 64'(grant), 64'h2);
      chk($sformatf("frz_dbg%0d", f), 64'(dbg_out), 64'(S1));
    end
    freeze = 1'b0;
    frame();
    chk("rel1_grant", 64'(grant), 64'h2);
    chk("rel1_dbg", 64'(dbg_out), 64'(S1B));
    frame();
    chk("rel2_grant", 64'(grant), 64'h2);
    frame();
    chk("rel3_grant", 64'(grant), 64'h8);
    chk("rel3_dbg", 64'(dbg_out), 64'(S3));

    // drop all requests -> IDLE, snapshot retained
    req = 4'b0000;
    frame();
    chk("drop_cs", 64'(cs), 64'd0);
    chk("drop_grant", 64'(grant), 64'd0);
    chk("drop_dbg", 64'(dbg_out), 64'(S3));

    // simultaneous requests from rr_ptr=0 -> lowest index 2
    req = 4'b1100;
    frame();
    chk("sim_page", 64'(page), 64'd2);
    chk("sim_dbg", 64'(dbg_out), 64'(S2));
    // granted source drops, another waiting -> hand over immediately
    req = 4'b1000;
    frame();
    chk("hand_page", 64'(page), 64'd3);
    chk("hand_cs", 64'(cs), 64'd1);

    // asynchronous mid-frame reset, then vsync stuck low across release
    @(negedge clk);
    #5 rst_n = 1'b0;
    #1;
    chk("arst_cs", 64'(cs), 64'd0);
    chk("arst_grant", 64'(grant), 64'd0);
    chk("arst_page", 64'(page), 64'd0);
    chk("arst_dbg", 64'(dbg_out), 64'd0);
    vsync = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("stuck_cs", 64'(cs), 64'd0);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    frame();
    chk("post_grant", 64'(grant), 64'h8);

    // page 0 with three requesters; step (when built in) advances to 1
    req = 4'b0000;
    frame();
    chk("idle2_cs", 64'(cs), 64'd0);
    req = 4'b0111;
    frame();
    chk("p0_page", 64'(page), 64'd0);
    chk("p0_dbg", 64'(dbg_out), 64'(S0));
`ifdef VISUMON_MANUAL_STEP_EN
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (2) @(negedge clk);
    frame();
    chk("step_page", 64'(page), 64'd1);
    chk("step_dbg", 64'(dbg_out), 64'(S1));
`else
    frame();
    chk("nostep_page", 64'(page), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/visumon_page_sched.md
# visumon_page_sched

Frame-synchronous scheduler that shares the single visuMon VGA debug monitor between up to N_SRC debug-info requesters (CPU, VIC, CIA, PLA probes). It round-robins grants among active requesters, dwells a fixed number of frames per page, and latches a tear-free snapshot of the granted source's debugInfo at each frame start. It sits between the probe sources and visuMon, driving visuMon's chip select and debug-info input and observing visuMon's vsync.

## Interface
- N_SRC, 4: number of requesters (2..8)
- DWELL_FRAMES, 60: frames a page stays shown while other requesters wait (1..255)
- i_clk25Mhz  in  1  pixel clock, 25 MHz; all logic on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_vsync  in  1  vsync from visuMon, active-low pulse; frame start = falling edge
- i_req  in  N_SRC  level request per source; bit k = source k wants display
- i_debugInfo  in  N_SRC x debugInfo  packed array, live probe data per source
- i_freeze  in  1  hold current page and snapshot
- o_cs  out  1  chip select to visuMon
- o_grant  out  N_SRC  one-hot granted source (0 when idle)
- o_page  out  $clog2(N_SRC)  index of granted source
- o_debugInfo  out  debugInfo  frame-stable snapshot to visuMon

## Operation
- frame_tick: i_vsync registered to vs_q; tick = vs_q & ~i_vsync. Only tick changes grant, page, snapshot or dwell count.
- FSM states: IDLE, SHOW.
- IDLE: o_cs=0, o_grant=0. On tick with i_req≠0: grant first requester at or after rr_ptr (round-robin search, wrapping modulo N_SRC), latch its debugInfo, dwell=0, o_cs=1, → SHOW.
- SHOW, on tick, priority order:
  - i_freeze=1: nothing changes, dwell not incremented.
  - granted req dropped: choose next requester after o_page; none → IDLE (o_cs=0, o_grant=0, snapshot retained).
  - dwell==DWELL_FRAMES-1 and another requester active: grant next one after o_page, rr_ptr=new page+1, dwell=0.
  - dwell==DWELL_FRAMES-1, no other requester: stay, dwell=0.
  - else: dwell+1; re-latch snapshot from granted source.
- Snapshot always taken from the source granted after the tick's decision.
- dwell is 8 bits; wrap never occurs (reset at DWELL_FRAMES-1).
- i_req changes between ticks are ignored until next tick.

## Timing
- Reset (async assert, sync release): state IDLE, o_cs=0, o_grant=0, o_page=0, o_debugInfo='0, dwell=0, rr_ptr=0, vs_q=1.
- Latency: outputs update on the clock edge where i_vsync is first sampled low (vs_q still 1); visible one cycle after fall.
- Held-low i_vsync yields exactly one tick; vsync stuck low after reset produces no tick.
- Reset mid-frame: all outputs return to reset values immediately; next grant only on a subsequent tick.
- Simultaneous requests: lowest index at or after rr_ptr wins.
- Mid-frame o_debugInfo, o_grant, o_page, o_cs are constant.

## Configuration
- VISUMON_MANUAL_STEP_EN defined: adds input i_step (1 bit, pulse). A step pulse is latched (sticky) and on the next tick forces advance to the next requester as if dwell expired; cleared on that tick; ignored while i_freeze=1 (remains pending).
- Undefined: no i_step port; rotation by dwell only.

## Structure
- Shared package (visuMon package alongside debugInfo typedef): sched_state_t enum {IDLE, SHOW}, DWELL_W=8 constant.
- Sub-module rr_pick: combinational round-robin priority search (req vector, start index → valid, index); instantiated for both IDLE search and rotation.

## Test plan
- Reset low 10 cycles, vsync toggling → o_cs=0, o_grant=0, o_debugInfo=0 throughout.
- i_req=4'b0010, one vsync fall → next cycle o_cs=1, o_grant=4'b0010, o_page=1, o_debugInfo=source 1 value.
- i_req=4'b1010, DWELL_FRAMES=3 → grant 1 for frames 1-3, grant 3 for frames 4-6, then 1 again.
- Change source 1 data mid-frame → o_debugInfo unchanged until next vsync fall.
- i_freeze=1 for 5 frames with i_req=4'b1010 → grant and snapshot unchanged; rotation resumes 3 frames after release.
- Drop i_req to 0 while SHOW → IDLE at next tick, o_cs=0; with VISUMON_MANUAL_STEP_EN, i_step with i_req=4'b0111 on page 0 → page 1 at next tick.
